// File: rtl/snoop_responder.sv
`default_nettype none
// ============================================================================
// Module   : snoop_responder
// Purpose  : Services shared-bus snoops from other caches against this L2.
//            It looks up tag/MESI through the directory port, answers with
//            NOHIT/HIT/HITM, and downgrades or invalidates the line. A HITM
//            response also streams the dirty line onto the bus, least
//            significant beat first.
// Revision : 1.0  initial release
// ============================================================================
module snoop_responder #(
  parameter int indexBits = 14,
  parameter int tagBits   = 12,
  parameter int ways      = 8,
  parameter int lineSize  = 512,
  parameter int busWidth  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     snoopValid,
  input  logic [1:0]               snoopOp,
  input  logic [indexBits-1:0]     snoopIndex,
  input  logic [tagBits-1:0]       snoopTag,
  output logic                     snoopReady,
  output logic                     snoopResultValid,
  output logic [1:0]               snoopResult,
  output logic                     protocolError,
  output logic                     dirReq,
  output logic [indexBits-1:0]     dirIndex,
  output logic [tagBits-1:0]       dirTag,
  input  logic                     dirAck,
  input  logic                     dirHit,
  input  logic [$clog2(ways)-1:0]  dirWay,
  input  logic [3:0]               dirMesi,
  input  logic [lineSize-1:0]      dirData,
  output logic                     dirWrEn,
  output logic [$clog2(ways)-1:0]  dirWrWay,
  output logic [3:0]               dirWrMesi,
  output logic                     wbValid,
  output logic [busWidth-1:0]      wbData,
  output logic                     wbLast,
  input  logic                     wbReady
);

  localparam int cBeats = lineSize / busWidth;
  localparam int cBeatW = (cBeats > 1) ? $clog2(cBeats) : 1;
  localparam logic [cBeatW-1:0] cLastBeat = cBeatW'(cBeats - 1);

  localparam logic [1:0] cOpRead  = 2'b00;
  localparam logic [1:0] cOpWrite = 2'b01;
  localparam logic [1:0] cOpRfo   = 2'b10;
  localparam logic [1:0] cOpInv   = 2'b11;

  localparam logic [1:0] cNohit = 2'b00;
  localparam logic [1:0] cHit   = 2'b01;
  localparam logic [1:0] cHitm  = 2'b10;

  localparam logic [3:0] cMesiM = 4'b1000;
  localparam logic [3:0] cMesiS = 4'b0010;
  localparam logic [3:0] cMesiI = 4'b0001;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    RESPOND   = 2'd2,
    WRITEBACK = 2'd3
  } stateT;

  stateT                    rState, wNext;
  logic [1:0]               rOp;
  logic [indexBits-1:0]     rIndex;
  logic [tagBits-1:0]       rTag;
  logic                     rHit;
  logic [$clog2(ways)-1:0]  rWay;
  logic [3:0]               rMesi;
  logic [lineSize-1:0]      rData;
  logic [cBeatW-1:0]        rBeat;

  logic       wLineValid;
  logic [1:0] wResult;
  logic       wWrite;
  logic [3:0] wNewMesi;
  logic       wProtErr;
  logic       wLastBeat;

  // A hit on an I-state way is treated exactly like a miss.
  assign wLineValid = rHit && !rMesi[0];
  assign wLastBeat  = (rBeat == cLastBeat);

  // The lookup address is only driven while the request is up.
  assign dirIndex = dirReq ? rIndex : '0;
  assign dirTag   = dirReq ? rTag   : '0;

  // State register; reset abandons any snoop in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rState <= IDLE;
    end else begin
      rState <= wNext;
    end
  end

  // Capture the snoop, latch the directory answer and count writeback beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rOp    <= '0;
      rIndex <= '0;
      rTag   <= '0;
      rHit   <= 1'b0;
      rWay   <= '0;
      rMesi  <= '0;
      rData  <= '0;
      rBeat  <= '0;
    end else begin
      if (rState == IDLE && snoopValid) begin
        rOp    <= snoopOp;
        rIndex <= snoopIndex;
        rTag   <= snoopTag;
        rHit   <= 1'b0;   // WRITE skips the lookup, so it must see a miss
      end
      if (rState == LOOKUP && dirAck) begin
        rHit  <= dirHit;
        rWay  <= dirWay;
        rMesi <= dirMesi;
        rData <= dirData;
      end
      if (rState == RESPOND) begin
        rBeat <= '0;
      end else if (rState == WRITEBACK && wbReady) begin
        rBeat <= rBeat + 1'b1;
      end
    end
  end

  // MESI response table: snoop result, directory update and protocol check.
  always_comb begin
    wResult  = cNohit;
    wWrite   = 1'b0;
    wNewMesi = cMesiI;
    wProtErr = 1'b0;
    if (wLineValid && rOp != cOpWrite) begin
      case (rOp)
        cOpRead: begin
          if (rMesi[3]) begin
            wResult = cHitm; wWrite = 1'b1; wNewMesi = cMesiS;
          end else if (rMesi[2]) begin
            wResult = cHit;  wWrite = 1'b1; wNewMesi = cMesiS;
          end else if (rMesi[1]) begin
            wResult = cHit;
          end
        end
        cOpRfo: begin
          if (rMesi[3]) begin
            wResult = cHitm; wWrite = 1'b1;
          end else if (rMesi[2] || rMesi[1]) begin
            wResult = cHit;  wWrite = 1'b1;
          end
        end
        cOpInv: begin
          // An INVALIDATE can only legally find a shared copy here.
          if (rMesi[1]) begin
            wResult = cHit; wWrite = 1'b1;
          end else if (rMesi[3] || rMesi[2]) begin
            wProtErr = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and all handshake outputs, derived from the state.
  always_comb begin
    wNext            = rState;
    snoopReady       = 1'b0;
    dirReq           = 1'b0;
    snoopResultValid = 1'b0;
    snoopResult      = cNohit;
    protocolError    = 1'b0;
    dirWrEn          = 1'b0;
    dirWrWay         = '0;
    dirWrMesi        = '0;
    wbValid          = 1'b0;
    wbData           = '0;
    wbLast           = 1'b0;
    case (rState)
      IDLE: begin
        snoopReady = 1'b1;
        if (snoopValid) begin
          wNext = (snoopOp == cOpWrite) ? RESPOND : LOOKUP;
        end
      end
      LOOKUP: begin
        dirReq = 1'b1;
        if (dirAck) begin
          wNext = RESPOND;
        end
      end
      RESPOND: begin
        snoopResultValid = 1'b1;
        snoopResult      = wResult;
        protocolError    = wProtErr;
        dirWrEn          = wWrite;
        dirWrWay         = wWrite ? rWay : '0;
        dirWrMesi        = wWrite ? wNewMesi : '0;
        wNext            = (wResult == cHitm) ? WRITEBACK : IDLE;
      end
      WRITEBACK: begin
        wbValid = 1'b1;
        wbData  = rData[int'(rBeat) * busWidth +: busWidth];
        wbLast  = wLastBeat;
        if (wbReady && wLastBeat) begin
          wNext = IDLE;
        end
      end
      default: wNext = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/snoop_responder.md
# snoop_responder

Bus-side snoop responder for the L2 cache model: it services shared-bus operations issued by *other* caches against this cache's lines. It is the counterpart of the cache's own read / read-for-ownership path. Per snoop it looks up tag and MESI state through the directory port and drives the snoop result (NOHIT/HIT/HITM). It then downgrades or invalidates the line and, on HITM, streams the modified line back onto the bus in beats.

## Interface
Parameters:
- indexBits, 14, set index width
- tagBits, 12, tag width
- ways, 8, associativity; way fields are $clog2(ways) bits
- lineSize, 512, line width in bits
- busWidth, 64, writeback beat width; lineSize must be an integer multiple of busWidth; beats = lineSize/busWidth

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- snoopValid  in  1  snoop operation presented
- snoopOp  in  2  00 READ, 01 WRITE, 10 RFO, 11 INVALIDATE
- snoopIndex  in  indexBits  snooped set
- snoopTag  in  tagBits  snooped tag
- snoopReady  out  1  responder can accept a snoop
- snoopResultValid  out  1  one-cycle result strobe
- snoopResult  out  2  00 NOHIT, 01 HIT, 10 HITM
- protocolError  out  1  one-cycle strobe: INVALIDATE hit a line in M or E
- dirReq  out  1  directory lookup request
- dirIndex  out  indexBits  lookup set
- dirTag  out  tagBits  lookup tag
- dirAck  in  1  lookup complete; dirHit, dirWay, dirMesi and dirData are valid
- dirHit  in  1  tag matched a non-I way
- dirWay  in  $clog2(ways)  matching way
- dirMesi  in  4  one-hot state: M=1000, E=0100, S=0010, I=0001
- dirData  in  lineSize  matching line data
- dirWrEn  out  1  one-cycle MESI update strobe
- dirWrWay  out  $clog2(ways)  way to update
- dirWrMesi  out  4  new one-hot state
- wbValid  out  1  writeback beat valid
- wbData  out  busWidth  writeback beat
- wbLast  out  1  final beat
- wbReady  in  1  bus accepts beat

## Operation
- Accept a snoop on the rising edge where snoopValid && snoopReady. On acceptance, capture op, index and tag.
- WRITE: go straight to RESPOND with NOHIT. No lookup is issued and no directory write is made.
- All other operations go to LOOKUP.
- States:
  - IDLE: snoopReady=1.
  - LOOKUP: dirReq=1 with the captured index and tag, held stable until dirAck. On dirAck, latch hit, way, mesi and data, then go to RESPOND.
  - RESPOND: snoopResultValid=1 for one cycle, and dirWrEn=1 in the same cycle if the state changes. Next state is WRITEBACK if the result is HITM, otherwise IDLE.
  - WRITEBACK: stream beats, return to IDLE after the wbLast beat is accepted.
- Response rules (miss or I gives NOHIT, no write, in every case):
  - READ: M→S, HITM. E→S, HIT. S stays S, HIT, no write.
  - RFO: M→I, HITM. E→I, HIT. S→I, HIT.
  - INVALIDATE: S→I, HIT. M or E: NOHIT, no write, protocolError=1 in RESPOND.
- Writeback:
  - Beat k carries latched data[k*busWidth +: busWidth], starting with k=0 (least-significant first).
  - wbData is held stable while wbValid && !wbReady.
  - The beat counter advances only on wbValid && wbReady.
  - wbLast=1 only when k=beats-1.
- A snoopValid asserted while busy is not accepted. The initiator holds it until snoopReady.

## Timing
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE and the beat counter to 0.
  - snoopReady=1.
  - All other outputs are 0: snoopResultValid, snoopResult, protocolError, dirReq, dirIndex, dirTag, dirWrEn, dirWrWay, dirWrMesi, wbValid, wbData, wbLast.
- Reset mid-operation abandons the snoop. No partial directory write or further beats follow after release.
- Accept at edge T, LOOKUP during cycle T+1:
  - dirReq first high in cycle T+1.
  - If dirAck is high in cycle T+1, RESPOND is in cycle T+2.
  - Each extra cycle of dirAck latency adds one cycle.
- WRITE snoop: RESPOND in cycle T+1.
- snoopReady returns high the cycle after RESPOND for non-HITM.
- HITM: the first beat is in the cycle after RESPOND. With wbReady held high, the writeback occupies beats cycles. snoopReady returns the cycle after the wbLast handshake.
- Back-to-back: with snoopValid held, the next snoop is accepted on the first edge where snoopReady=1.

## Test plan
- Reset then READ to index 0x0005, tag 0x0AB, dirAck in T+1 with dirHit=1, way 3, mesi=0100 (E) → RESPOND at T+2: snoopResult=01, dirWrEn=1, dirWrWay=3, dirWrMesi=0010; snoopReady=1 at T+3.
- RFO hits M line, way 7, dirData has beat k = 64'h1111_1111_1111_1111·(k+1), wbReady toggles 1,0,1,… → HITM, dirWrMesi=0001, 8 beats in ascending order, each held through wbReady=0, wbLast only on beat 7.
- WRITE snoop → no dirReq, snoopResult=00 at T+1, no dirWrEn.
- INVALIDATE hits E line → snoopResult=00, protocolError=1 for one cycle, no dirWrEn.
- READ hits S line with dirAck delayed 3 cycles → dirReq/dirIndex/dirTag stable for 3 cycles, HIT, no dirWrEn.
- Assert rst_n=0 during beat 3 of a HITM writeback → wbValid falls immediately, snoopReady=1, no further beats after release; next READ miss → NOHIT.
